// File: rtl/sram_arb2.sv
// sram_arb2: round-robin arbiter sharing one single-port synchronous SRAM between two requesters
// ports: clk/rst; req_valid/req_ready/req_we/req_addr/req_wdata command handshake per requester;
// rsp_valid/rsp_rdata read response; busy; mem_enable/mem_r_w/mem_address/mem_datain/mem_dataout SRAM pins
module sram_arb2 #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0]            req_we,
  input  logic [2*ADDR_W-1:0]   req_addr,
  input  logic [2*DATA_W-1:0]   req_wdata,
  output logic [1:0]            rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  busy,
  output logic                  mem_enable,
  output logic                  mem_r_w,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W-1:0]     mem_datain,
  input  logic [DATA_W-1:0]     mem_dataout
);
  typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT} state_t;
  state_t state;
  logic last_gnt, c_we, c_own, win, hs, iss;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic [1:0] grant;
  // on a tie the requester that did not win last time gets the slot
  always_comb grant = (req_valid == 2'b11) ? (last_gnt ? 2'b01 : 2'b10) : req_valid;
  assign req_ready   = (state == IDLE && !rst) ? grant : 2'b00;
  assign win         = req_ready[1];
  assign hs          = |req_ready;
  assign iss         = state == ISSUE;
  assign busy        = state != IDLE && !rst;
  assign mem_enable  = iss && !rst;
  assign mem_r_w     = iss ? c_we : 1'b0;
  assign mem_address = iss ? c_addr : '0;
  assign mem_datain  = iss ? c_wdata : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last_gnt  <= 1'b1;
      c_we      <= 1'b0;
      c_own     <= 1'b0;
      c_addr    <= '0;
      c_wdata   <= '0;
      rsp_valid <= 2'b00;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 2'b00;
      case (state)
        IDLE: if (hs) begin
          state    <= ISSUE;
          last_gnt <= win;
          c_own    <= win;
          c_we     <= req_we[win];
          c_addr   <= win ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
          c_wdata  <= win ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
        end
        ISSUE: state <= c_we ? IDLE : RDWAIT;
        RDWAIT: begin
          // SRAM output is registered: the read issued last cycle is on mem_dataout now
          rsp_rdata <= mem_dataout;
          rsp_valid <= c_own ? 2'b10 : 2'b01;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_arb2.sv
// tb_sram_arb2: randomized and directed checks of sram_arb2 against a transaction-timing model
module tb_sram_arb2;
  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] req_valid = 2'b00, req_ready, req_we = 2'b00, rsp_valid;
  logic [9:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic [7:0] rsp_rdata, mem_datain, mem_dataout;
  logic busy, mem_enable, mem_r_w;
  logic [4:0] mem_address;
  logic [7:0] sram [32];
  int checks = 0, errors = 0, cyc = 0;
  int idle_at = 0, hs_cyc = -100, rsp_at = -100;
  logic m_last = 1'b1, pend = 1'b0, rsp_own = 1'b0, c_we = 1'b0, c_own = 1'b0, inited = 1'b0;
  logic [4:0] c_addr = '0;
  logic [7:0] c_wdata = '0, rsp_dat = '0, exp_rdata = '0;
  logic [1:0] exp_vld = 2'b00;
  logic [7:0] mm [32];
  int rec_cyc = -1, rsp_n = 0, hs_at [2] = '{-1, -1};
  logic [1:0] rec_vec = 2'b00;
  logic [7:0] rec_dat = '0;
  logic en_seen = 1'b0, rec_en = 1'b0;
  int gq [$];
  logic [9:0] rq [$];

  sram_arb2 dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .busy(busy), .mem_enable(mem_enable), .mem_r_w(mem_r_w), .mem_address(mem_address),
    .mem_datain(mem_datain), .mem_dataout(mem_dataout)
  );

  always #5 clk = ~clk;

  // SRAM: registered output, cleared whenever enable is low at an edge
  always @(posedge clk) begin
    if (mem_enable) begin
      if (mem_r_w) sram[mem_address] <= mem_datain;
      else mem_dataout <= sram[mem_address];
    end else mem_dataout <= '0;
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", n, cyc, a, e);
    end
  endtask

  // one clock cycle: drive inputs, compare outputs against the model, advance the model
  task automatic step(input logic [1:0] v, input logic [1:0] w, input logic [9:0] a,
                      input logic [15:0] d, input logic r);
    logic idle, iss, wn;
    logic [1:0] er, nv;
    logic [7:0] nd;
    @(posedge clk);
    #1;
    req_valid = v; req_we = w; req_addr = a; req_wdata = d; rst = r;
    @(negedge clk);
    idle = cyc >= idle_at;
    iss  = cyc == hs_cyc + 1;
    wn   = (v == 2'b11) ? ~m_last : v[1];
    er   = (idle && !r && v != 2'b00) ? (wn ? 2'b10 : 2'b01) : 2'b00;
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("busy", 32'(busy), 32'(!idle && !r));
    chk("mem_enable", 32'(mem_enable), 32'(iss && !r));
    if (!r) begin
      chk("mem_r_w", 32'(mem_r_w), 32'(iss ? c_we : 1'b0));
      chk("mem_address", 32'(mem_address), 32'(iss ? c_addr : 5'd0));
      chk("mem_datain", 32'(mem_datain), 32'(iss ? c_wdata : 8'd0));
    end
    if (inited) begin
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_vld));
      chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_rdata));
    end
    if (rsp_valid != 2'b00) begin
      rec_cyc = cyc; rec_vec = rsp_valid; rec_dat = rsp_rdata; rsp_n++;
      rq.push_back({rsp_valid, rsp_rdata});
    end
    for (int i = 0; i < 2; i++)
      if (req_valid[i] && req_ready[i]) begin hs_at[i] = cyc; gq.push_back(i); end
    en_seen = en_seen | mem_enable | busy | (|req_ready);
    rec_en = mem_enable;
    if (iss && !r) begin
      if (c_we) mm[c_addr] = c_wdata;
      else begin pend = 1'b1; rsp_at = cyc + 2; rsp_dat = mm[c_addr]; rsp_own = c_own; end
    end
    nv = (!r && pend && rsp_at == cyc + 1) ? (rsp_own ? 2'b10 : 2'b01) : 2'b00;
    nd = r ? 8'd0 : (nv != 2'b00 ? rsp_dat : exp_rdata);
    if (r || rsp_at <= cyc + 1) pend = 1'b0;
    if (r) begin
      idle_at = cyc + 1; hs_cyc = -100; m_last = 1'b1;
    end else if (er != 2'b00) begin
      hs_cyc  = cyc;
      idle_at = cyc + (w[wn] ? 2 : 3);
      c_we    = w[wn];
      c_own   = wn;
      c_addr  = wn ? a[9:5] : a[4:0];
      c_wdata = wn ? d[15:8] : d[7:0];
      m_last  = wn;
    end
    exp_vld = nv; exp_rdata = nd;
    inited = inited | r;
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) step(2'b00, 2'b00, '0, '0, 1'b0);
  endtask

  // present one command on requester i until it is accepted; hc = handshake cycle
  task automatic cmd(input int i, input logic w, input logic [4:0] a, input logic [7:0] dd,
                     output int hc);
    int start;
    start = cyc;
    hc = -1;
    for (int k = 0; k < 10 && hc < 0; k++) begin
      step(i == 1 ? 2'b10 : 2'b01, {w, w}, {a, a}, {dd, dd}, 1'b0);
      if (hs_at[i] >= start) hc = hs_at[i];
    end
    if (hc < 0) begin errors++; $display("FAIL cmd_timeout req=%0d got=none expected=handshake", i); end
  endtask

  initial begin
    int h, n, k;
    for (int i = 0; i < 32; i++) mm[i] = '0;
    step(2'b00, 2'b00, '0, '0, 1'b1);
    step(2'b11, 2'b00, '0, '0, 1'b1);
    chk("reset_ready", 32'(req_ready), 32'd0);
    for (int i = 0; i < 32; i++) cmd(0, 1'b1, 5'(i), 8'($urandom), h);
    idle(1);
    // T1
    cmd(0, 1'b1, 5'd5, 8'hA5, h);
    cmd(0, 1'b0, 5'd5, 8'h00, h);
    idle(3);
    chk("t1_latency", 32'(rec_cyc - h), 32'd3);
    chk("t1_vec", 32'(rec_vec), 32'd1);
    chk("t1_data", 32'(rec_dat), 32'hA5);
    // T2
    cmd(0, 1'b1, 5'd1, 8'h5A, h);
    cmd(1, 1'b1, 5'd2, 8'hC3, h);
    idle(1);
    step(2'b00, 2'b00, '0, '0, 1'b1);
    gq.delete(); rq.delete();
    repeat (12) step(2'b11, 2'b00, {5'd2, 5'd1}, '0, 1'b0);
    idle(2);
    chk("t2_grants", 32'(gq.size()), 32'd4);
    if (gq.size() == 4) begin
      chk("t2_g0", 32'(gq[0]), 32'd0); chk("t2_g1", 32'(gq[1]), 32'd1);
      chk("t2_g2", 32'(gq[2]), 32'd0); chk("t2_g3", 32'(gq[3]), 32'd1);
    end
    chk("t2_rsps", 32'(rq.size()), 32'd4);
    if (rq.size() >= 2) begin
      chk("t2_r0", 32'(rq[0]), 32'h15A);
      chk("t2_r1", 32'(rq[1]), 32'h2C3);
    end
    // T3: last winner must be req0 so req1 wins the tie
    cmd(0, 1'b1, 5'd0, 8'h77, h);
    idle(1);
    n = cyc;
    step(2'b11, 2'b10, {5'd31, 5'd31}, {8'h3C, 8'h00}, 1'b0);
    chk("t3_req1_hs", 32'(hs_at[1]), 32'(n));
    cmd(0, 1'b0, 5'd31, 8'h00, h);
    chk("t3_req0_hs", 32'(h - n), 32'd2);
    idle(3);
    chk("t3_data", 32'(rec_dat), 32'h3C);
    chk("t3_vec", 32'(rec_vec), 32'd1);
    // T4
    cmd(0, 1'b1, 5'd7, 8'h11, h);
    idle(1);
    cmd(0, 1'b1, 5'd7, 8'hFF, h);
    step(2'b00, 2'b00, '0, '0, 1'b1);
    chk("t4_enable_in_rst", 32'(rec_en), 32'd0);
    cmd(1, 1'b0, 5'd7, 8'h00, h);
    idle(3);
    chk("t4_data", 32'(rec_dat), 32'h11);
    // T5
    cmd(1, 1'b0, 5'd7, 8'h00, h);
    k = rsp_n;
    idle(1);
    step(2'b00, 2'b00, '0, '0, 1'b1);
    idle(3);
    chk("t5_no_rsp", 32'(rsp_n), 32'(k));
    cmd(1, 1'b0, 5'd7, 8'h00, h);
    idle(3);
    chk("t5_data", 32'(rec_dat), 32'h11);
    chk("t5_vec", 32'(rec_vec), 32'd2);
    // T6
    en_seen = 1'b0;
    idle(10);
    chk("t6_quiet", 32'(en_seen), 32'd0);
    // random traffic
    for (int i = 0; i < 3000; i++)
      step(2'($urandom), 2'($urandom), {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))},
           16'($urandom), $urandom_range(0, 49) == 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
